// File: rtl/regfile_pkg.sv
// Shared defaults and types for the architectural register file and its
// pending-load scoreboard.
package regfile_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_ADDR_WIDTH = 5;
    localparam int NUM_REGS           = 2**DEFAULT_ADDR_WIDTH;
    localparam int REG_ZERO           = 0;

    typedef logic [DEFAULT_ADDR_WIDTH-1:0] reg_idx_t;
    typedef logic [DEFAULT_DATA_WIDTH-1:0] reg_data_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-load scoreboard: one bit per register, set on load issue and
// cleared on load writeback. Optional same-cycle clear bypass via REGFILE_BYPASS_EN.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ldIssue,
    input  logic [ADDR_WIDTH-1:0] ldRd,
    input  logic                  loadWb,
    input  logic [ADDR_WIDTH-1:0] wbRd,
    input  logic [ADDR_WIDTH-1:0] rs1,
    input  logic [ADDR_WIDTH-1:0] rs2,
    output logic                  busy1,
    output logic                  busy2
);

    localparam int NREGS = 2**ADDR_WIDTH;

    logic [NREGS-1:0] pending;
    logic [NREGS-1:0] pendingNext;
    logic             setHit;
    logic             clrHit;
    logic             fwd1;
    logic             fwd2;

    assign setHit = ldIssue && (int'(ldRd) != REG_ZERO);
    assign clrHit = loadWb  && (int'(wbRd) != REG_ZERO);

    // Clear first so that a newer load to the same register keeps it pending.
    always_comb begin
        pendingNext = pending;
        if (clrHit) begin
            pendingNext[wbRd] = 1'b0;
        end
        if (setHit) begin
            pendingNext[ldRd] = 1'b1;
        end
        pendingNext[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending <= '0;
        end else begin
            pending <= pendingNext;
        end
    end

`ifdef REGFILE_BYPASS_EN
    assign fwd1 = clrHit && (wbRd == rs1);
    assign fwd2 = clrHit && (wbRd == rs2);
`else
    assign fwd1 = 1'b0;
    assign fwd2 = 1'b0;
`endif

    assign busy1 = pending[rs1] & ~fwd1;
    assign busy2 = pending[rs2] & ~fwd2;

endmodule

// File: rtl/register_file.sv
// Architectural register file with two combinational read ports, x0 hardwired
// to zero, and a load scoreboard. Optional write-to-read bypass: REGFILE_BYPASS_EN.
module register_file
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  regwriteW,
    input  logic [ADDR_WIDTH-1:0] rdW,
    input  logic [DATA_WIDTH-1:0] resultW,
    input  logic                  isloadW,
    input  logic                  ld_issueE,
    input  logic [ADDR_WIDTH-1:0] ld_rdE,
    input  logic [ADDR_WIDTH-1:0] rs1D,
    input  logic [ADDR_WIDTH-1:0] rs2D,
    output logic [DATA_WIDTH-1:0] rd1D,
    output logic [DATA_WIDTH-1:0] rd2D,
    output logic                  busy1D,
    output logic                  busy2D,
    output logic                  stallD
);

    localparam int NREGS = 2**ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [NREGS];
    logic                  writeHit;

    assign writeHit = regwriteW && (int'(rdW) != REG_ZERO);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (writeHit) begin
            regs[rdW] <= resultW;
        end
    end

    // Reads are gated by reset so a bypassed writeback cannot leak out while held in reset.
    always_comb begin
        rd1D = '0;
        rd2D = '0;
        if (rst) begin
            if (int'(rs1D) != REG_ZERO) begin
                rd1D = regs[rs1D];
`ifdef REGFILE_BYPASS_EN
                if (writeHit && (rdW == rs1D)) begin
                    rd1D = resultW;
                end
`endif
            end
            if (int'(rs2D) != REG_ZERO) begin
                rd2D = regs[rs2D];
`ifdef REGFILE_BYPASS_EN
                if (writeHit && (rdW == rs2D)) begin
                    rd2D = resultW;
                end
`endif
            end
        end
    end

    regfile_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) scoreboard (
        .clk     (clk),
        .rst     (rst),
        .ldIssue (ld_issueE),
        .ldRd    (ld_rdE),
        .loadWb  (regwriteW && isloadW),
        .wbRd    (rdW),
        .rs1     (rs1D),
        .rs2     (rs2D),
        .busy1   (busy1D),
        .busy2   (busy2D)
    );

    assign stallD = busy1D | busy2D;

endmodule

// File: tb/tb_register_file.sv
// Randomized self-checking bench for register_file against an array-based
// reference model; honours REGFILE_BYPASS_EN when the build defines it.
module tb_register_file;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 32;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          regwriteW;
    logic [AW-1:0] rdW;
    logic [DW-1:0] resultW;
    logic          isloadW;
    logic          ld_issueE;
    logic [AW-1:0] ld_rdE;
    logic [AW-1:0] rs1D;
    logic [AW-1:0] rs2D;
    logic [DW-1:0] rd1D;
    logic [DW-1:0] rd2D;
    logic          busy1D;
    logic          busy2D;
    logic          stallD;

    int compareCount  = 0;
    int mismatchCount = 0;

    logic [DW-1:0] modelRegs [NR];
    bit            modelPending [NR];

    always #5 clk = ~clk;

    register_file dut (
        .clk       (clk),
        .rst       (rst),
        .regwriteW (regwriteW),
        .rdW       (rdW),
        .resultW   (resultW),
        .isloadW   (isloadW),
        .ld_issueE (ld_issueE),
        .ld_rdE    (ld_rdE),
        .rs1D      (rs1D),
        .rs2D      (rs2D),
        .rd1D      (rd1D),
        .rd2D      (rd2D),
        .busy1D    (busy1D),
        .busy2D    (busy2D),
        .stallD    (stallD)
    );

    task automatic checkOutput(input string tag, input logic [DW-1:0] observed,
                               input logic [DW-1:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    function automatic logic [DW-1:0] expectRead(input logic [AW-1:0] rs);
        if (!rst || rs == 0) return '0;
        if (BYPASS && regwriteW && rdW != 0 && rdW == rs) return resultW;
        return modelRegs[rs];
    endfunction

    function automatic logic expectBusy(input logic [AW-1:0] rs);
        if (!rst) return 1'b0;
        if (BYPASS && regwriteW && isloadW && rdW != 0 && rdW == rs) return 1'b0;
        return modelPending[rs];
    endfunction

    task automatic modelReset();
        for (int i = 0; i < NR; i++) begin
            modelRegs[i]    = '0;
            modelPending[i] = 1'b0;
        end
    endtask

    task automatic applyStimulus(input logic we, input logic [AW-1:0] rd, input logic [DW-1:0] res,
                                 input logic isLoad, input logic issue, input logic [AW-1:0] ldRd,
                                 input logic [AW-1:0] rs1, input logic [AW-1:0] rs2);
        @(negedge clk);
        regwriteW = we;
        rdW       = rd;
        resultW   = res;
        isloadW   = isLoad;
        ld_issueE = issue;
        ld_rdE    = ldRd;
        rs1D      = rs1;
        rs2D      = rs2;
        #1;
    endtask

    task automatic checkPorts(input string tag);
        logic b1;
        logic b2;
        b1 = expectBusy(rs1D);
        b2 = expectBusy(rs2D);
        checkOutput({tag, "_rd1"}, rd1D, expectRead(rs1D));
        checkOutput({tag, "_rd2"}, rd2D, expectRead(rs2D));
        checkOutput({tag, "_busy1"}, {31'b0, busy1D}, {31'b0, b1});
        checkOutput({tag, "_busy2"}, {31'b0, busy2D}, {31'b0, b2});
        checkOutput({tag, "_stall"}, {31'b0, stallD}, {31'b0, b1 | b2});
    endtask

    // Advance the model by the effect of the current inputs, then take the edge.
    task automatic clockModel();
        if (rst) begin
            if (regwriteW && rdW != 0) modelRegs[rdW] = resultW;
            if (regwriteW && isloadW && rdW != 0) modelPending[rdW] = 1'b0;
            if (ld_issueE && ld_rdE != 0) modelPending[ld_rdE] = 1'b1;
        end
        @(posedge clk);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [DW-1:0] val;
        rst = 1'b0;
        regwriteW = 0; rdW = 0; resultW = 0; isloadW = 0;
        ld_issueE = 0; ld_rdE = 0; rs1D = 5; rs2D = 7;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkPorts("reset");
        @(negedge clk);
        rst = 1'b1;

        // Basic write and next-cycle read
        applyStimulus(1, 5, 32'hDEADBEEF, 0, 0, 0, 5, 0);
        checkOutput("t1_sameCycle", rd1D, BYPASS ? 32'hDEADBEEF : 32'h0);
        checkPorts("t1w");
        clockModel();
        applyStimulus(0, 0, 0, 0, 0, 0, 5, 0);
        checkOutput("t1_nextCycle", rd1D, 32'hDEADBEEF);
        clockModel();

        // Writes to x0 are dropped
        applyStimulus(1, 0, 32'h12345678, 0, 0, 0, 0, 0);
        checkOutput("t2_x0Same", rd1D, 32'h0);
        clockModel();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 5);
        checkOutput("t2_x0Next", rd1D, 32'h0);
        checkPorts("t2");
        clockModel();

        // Load to r7 stalls decode until its writeback
        applyStimulus(0, 0, 0, 0, 1, 7, 0, 7);
        checkOutput("t3_issueCycle", {31'b0, busy2D}, 32'h0);
        clockModel();
        for (int i = 0; i < 2; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 7);
            checkOutput("t3_busy2", {31'b0, busy2D}, 32'h1);
            checkOutput("t3_stall", {31'b0, stallD}, 32'h1);
            clockModel();
        end
        applyStimulus(1, 7, 32'hA5A5_0007, 1, 0, 0, 0, 7);
        checkOutput("t3_wbCycleBusy", {31'b0, busy2D}, BYPASS ? 32'h0 : 32'h1);
        clockModel();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 7);
        checkOutput("t3_clearedBusy", {31'b0, busy2D}, 32'h0);
        checkOutput("t3_loadData", rd2D, 32'hA5A5_0007);
        clockModel();

        // Set and clear of the same register at one edge: set wins
        applyStimulus(0, 0, 0, 0, 1, 9, 0, 0);
        clockModel();
        applyStimulus(1, 9, 32'h0000_0909, 1, 1, 9, 0, 9);
        checkPorts("t4w");
        clockModel();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 9);
        checkOutput("t4_stillBusy", {31'b0, busy2D}, 32'h1);
        clockModel();

        // Set and clear of different registers at one edge
        applyStimulus(0, 0, 0, 0, 1, 4, 0, 0);
        clockModel();
        applyStimulus(1, 4, 32'h0000_0404, 1, 1, 3, 3, 4);
        checkPorts("t5w");
        clockModel();
        applyStimulus(0, 0, 0, 0, 0, 0, 3, 4);
        checkOutput("t5_busy3", {31'b0, busy1D}, 32'h1);
        checkOutput("t5_busy4", {31'b0, busy2D}, 32'h0);
        clockModel();

        // Random traffic, biased toward low indices so hazards collide often
        for (int i = 0; i < 400; i++) begin
            int hi;
            hi = (i % 3 == 0) ? 31 : 7;
            applyStimulus(($urandom % 4) != 0, AW'($urandom_range(0, hi)), $urandom,
                          ($urandom % 2) == 1, ($urandom % 3) == 0, AW'($urandom_range(0, hi)),
                          AW'($urandom_range(0, hi)), AW'($urandom_range(0, hi)));
            checkPorts("rand");
            clockModel();
        end

        // Fill every register, mark a few pending, then reset mid-cycle
        for (int r = 1; r < NR; r++) begin
            applyStimulus(1, AW'(r), 32'hC0DE_0000 + DW'(r), 0, 0, 0, AW'(r), 0);
            clockModel();
        end
        applyStimulus(0, 0, 0, 0, 1, 2, 0, 0);
        clockModel();
        applyStimulus(0, 0, 0, 0, 1, 11, 0, 0);
        clockModel();
        applyStimulus(0, 0, 0, 0, 0, 0, 17, 11);
        checkPorts("preRst");
        checkOutput("preRst_busy11", {31'b0, busy2D}, 32'h1);
        applyStimulus(1, 6, 32'hFEED_0006, 1, 1, 12, 6, 11);
        #1;
        rst = 1'b0;
        modelReset();
        #1;
        checkPorts("rstMid");
        checkOutput("rstMid_rd1", rd1D, 32'h0);
        checkOutput("rstMid_busy2", {31'b0, busy2D}, 32'h0);
        clockModel();
        #1;
        rs2D = 12;
        #1;
        checkPorts("rstHeld");
        #2;
        rst = 1'b1;
        val = 32'h600D_0006;
        applyStimulus(1, 6, val, 0, 0, 0, 17, 11);
        checkPorts("postRstW");
        clockModel();
        applyStimulus(0, 0, 0, 0, 0, 0, 6, 17);
        checkOutput("postRst_write", rd1D, 32'h600D_0006);
        checkOutput("postRst_cleared", rd2D, 32'h0);
        checkPorts("postRst");
        clockModel();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule

// File: doc/register_file.md
# register_file

Architectural register file that terminates the pipeline's writeback interface: it absorbs `resultW`, `regwriteW` and `rdW` from the writeback stage and serves two decode-stage read ports. It also keeps a pending-load scoreboard so decode can stall on registers whose load data has not yet been written back. Register 0 is hardwired to zero.

## Interface

Parameters:
- `DATA_WIDTH`, 32: register width.
- `ADDR_WIDTH`, 5: register index width; `2**ADDR_WIDTH` registers.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `regwriteW`  in  1  writeback write enable.
- `rdW`  in  ADDR_WIDTH  writeback destination index.
- `resultW`  in  DATA_WIDTH  writeback data.
- `isloadW`  in  1  the writeback being presented is a load result; clears the scoreboard entry.
- `ld_issueE`  in  1  a load to `ld_rdE` enters execute this cycle; sets the scoreboard entry.
- `ld_rdE`  in  ADDR_WIDTH  destination of the issuing load.
- `rs1D`, `rs2D`  in  ADDR_WIDTH  decode read indices.
- `rd1D`, `rd2D`  out  DATA_WIDTH  read data, combinational from the read indices.
- `busy1D`, `busy2D`  out  1  the read register has a load outstanding.
- `stallD`  out  1  `busy1D | busy2D`.

## Operation

- Storage holds `2**ADDR_WIDTH` entries of DATA_WIDTH bits.
- Write: on a rising edge with `regwriteW=1` and `rdW!=0`, the entry at `rdW` takes `resultW`.
  - When `rdW==0`, the write is dropped.
  - Entry 0 always reads 0.
- Read: `rdND = (rsND==0) ? 0 : storage[rsND]`. The read is asynchronous, with no latency.
- Scoreboard: a `2**ADDR_WIDTH`-bit pending vector; bit 0 is always 0.
  - Set: at the edge where `ld_issueE=1` and `ld_rdE!=0`, `pending[ld_rdE]` becomes 1.
  - Clear: at the edge where `regwriteW & isloadW` is true and `rdW!=0`, `pending[rdW]` becomes 0.
  - Set and clear of the same index at the same edge: set wins, because a newer load supersedes the older one.
  - Set and clear of different indices at the same edge: both take effect.
  - `busyND = pending[rsND]`, subject to the bypass rule in Configuration.
- A non-load writeback (`isloadW=0`) never alters the scoreboard.
- Reset (`rst=0`, asynchronous, any time including mid-operation): all storage entries and all pending bits go to 0 immediately.
  - While in reset, `rd1D`, `rd2D`, `busy1D`, `busy2D` and `stallD` are all 0.
  - Writes and scoreboard updates are ignored until the first rising edge after `rst` deasserts.

## Timing

- A write presented in cycle N is visible on the read ports from cycle N+1 without bypass, or in cycle N with bypass.
- A scoreboard set at edge N makes `busy` 1 from cycle N+1.
- A scoreboard clear at edge N makes `busy` 0 from cycle N+1 without bypass, or in cycle N with bypass.
- Read paths are purely combinational. They have no clocked output registers.

## Configuration

- `REGFILE_BYPASS_EN` defined:
  - When `regwriteW=1`, `rdW!=0` and `rdW==rsND`, `rdND` returns `resultW` in the same cycle.
  - In that same case, when `isloadW=1` also holds, `busyND` is forced to 0 for that cycle.
- `REGFILE_BYPASS_EN` undefined:
  - `rdND` returns stored data only, and `busyND` follows `pending` directly.
  - Decode stalls one extra cycle on a load-use hazard.
- All other behaviour is identical in both builds.

## Structure

- Shared package `regfile_pkg` holds:
  - the `DATA_WIDTH` and `ADDR_WIDTH` defaults;
  - `NUM_REGS = 2**ADDR_WIDTH`;
  - `REG_ZERO = 0`;
  - typedefs `reg_idx_t` and `reg_data_t`.
- Sub-module `regfile_scoreboard` contains the pending vector, the set/clear priority logic and the two busy lookups, including the bypass override.
- The top level contains the storage array, the read muxes and the `stallD` OR.

## Test plan

- Reset, then write `resultW=32'hDEADBEEF` to `rdW=5` with `rs1D=5`: the next cycle `rd1D=32'hDEADBEEF`. With bypass, `rd1D` already equals `32'hDEADBEEF` in the write cycle.
- Write `32'h12345678` to `rdW=0`: `rd1D` with `rs1D=0` stays 0 forever.
- `ld_issueE=1`, `ld_rdE=7`, then `rs2D=7`: `busy2D=1` and `stallD=1` until the load writeback (`isloadW=1`, `rdW=7`). The clear is visible one cycle later without bypass, or in the same cycle with bypass.
- Same edge, `ld_issueE` to reg 9 and load writeback to reg 9: `pending[9]` stays 1.
- Same edge, issue to reg 3 and load writeback to reg 4: reg 3 becomes busy and reg 4 clears.
- Fill registers 1–31 with distinct values and set several pending bits, then pulse `rst` low mid-cycle: all reads and busy flags are 0 immediately, and a write on the first edge after release succeeds.
